// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   - RV32I load/store funct3 encodings
//   - controller state encoding
//   - bytes per RAM word and a funct3 legality helper
package dmem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORD_BYTES = 4;
    localparam int OFF_BITS   = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] || (f3 == 3'b011);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data RAM.
// Ports:
//   old_word   in  32  current RAM word (read before the write)
//   wdata      in  32  right-aligned store data
//   funct3     in  3   load/store size/sign encoding
//   byte_off   in  2   byte offset within the word
//   store_word out 32  old_word with the addressed lanes replaced
//   load_data  out 32  addressed lane(s), sign- or zero-extended
//   misalign   out 1   halfword on odd address or word not on a word boundary
module mem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = old_word[7:0];
        case (byte_off)
            2'd0: byte_sel = old_word[7:0];
            2'd1: byte_sel = old_word[15:8];
            2'd2: byte_sel = old_word[23:16];
            2'd3: byte_sel = old_word[31:24];
            default: byte_sel = old_word[7:0];
        endcase
        half_sel = byte_off[1] ? old_word[31:16] : old_word[15:0];
    end

    always_comb begin
        load_data = old_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = old_word;
        endcase
    end

    always_comb begin
        store_word = wdata;
        case (funct3)
            F3_B: begin
                store_word = old_word;
                store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_word = old_word;
                store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = byte_off[0];
            2'b10:   misalign = (byte_off != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Initiator-side controller for a synchronous-read, word-wide data RAM.
// One load/store in flight; sub-word stores are read-modify-write.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for a request; accepts on req_valid & req_ready
//   ACCESS | RAM samples the latched word index at the end of this cycle
//   DATA   | old word on ram_data_out; merged store written, load captured
//   RESP   | resp_valid pulse, resp_err/resp_rdata stable
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                         request fields (latched on accept)
//   resp_valid, resp_err, resp_rdata  one-cycle completion with status/data
//   ram_wr_en, ram_data_in,
//   ram_addr_wr, ram_addr_rd          RAM controls (word-indexed addresses)
//   ram_data_out                      RAM read data, one cycle after addr_rd
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int MEM_WORDS  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [31:0]           ram_addr_wr,
    output logic [31:0]           ram_addr_rd,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    state_e state, state_nxt;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [31:0]           word_idx;
    logic [DATA_WIDTH-1:0] store_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  misalign;
    logic                  fault;
    logic                  accept;

    assign word_idx    = {{OFF_BITS{1'b0}}, addr_q[31:OFF_BITS]};
    assign ram_addr_rd = word_idx;
    assign ram_addr_wr = word_idx;

    assign fault  = misalign
                  || (word_idx >= 32'(MEM_WORDS))
                  || f3_illegal(we_q, f3_q);
    assign accept = req_valid && req_ready;

    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    mem_lane_align u_lane (
        .old_word   (ram_data_out),
        .wdata      (wdata_q),
        .funct3     (f3_q),
        .byte_off   (addr_q[1:0]),
        .store_word (store_word),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DATA;
            ST_DATA:   state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // All handshake and RAM strobes are gated by reset so an aborted
    // transaction can neither write nor respond in the reset cycle.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        ram_wr_en   = 1'b0;
        ram_data_in = '0;
        if (!reset) begin
            case (state)
                ST_IDLE: req_ready = 1'b1;
                ST_DATA: begin
                    if (we_q && !fault) begin
                        ram_wr_en   = 1'b1;
                        ram_data_in = store_word;
                    end
                end
                ST_RESP: resp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ST_DATA) begin
                err_q   <= fault;
                rdata_q <= (fault || we_q) ? '0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        ram_wr_en;
    logic [31:0] ram_data_in;
    logic [31:0] ram_addr_wr;
    logic [31:0] ram_addr_rd;
    logic [31:0] ram_data_out;

    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    int resp_total = 0;
    logic [31:0] resp_q[$];
    logic        mem_init;
    logic [31:0] mem [MEM_WORDS];

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .ram_wr_en    (ram_wr_en),
        .ram_data_in  (ram_data_in),
        .ram_addr_wr  (ram_addr_wr),
        .ram_addr_rd  (ram_addr_rd),
        .ram_data_out (ram_data_out)
    );

    // Synchronous-read RAM; word i preloads to 0x1000_0000 + i.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (ram_wr_en && ram_addr_wr < 32'(MEM_WORDS)) begin
            mem[ram_addr_wr[5:0]] <= ram_data_in;
        end
        ram_data_out <= (ram_addr_rd < 32'(MEM_WORDS)) ? mem[ram_addr_rd[5:0]] : 32'h0;
    end

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            resp_total++;
            resp_q.push_back(resp_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic exp_wr,
                          input logic [31:0] exp_din, input string tag);
        chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_ready_access"}, 32'(req_ready), 32'd0);
        chk({tag, "_wr_access"}, 32'(ram_wr_en), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'(exp_wr));
        if (exp_wr) chk({tag, "_data_in"}, ram_data_in, exp_din);
        chk({tag, "_addr_wr"}, ram_addr_wr, {2'b00, addr[31:2]});
        chk({tag, "_rv_data"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rv"}, 32'(resp_valid), 32'd1);
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_wr_resp"}, 32'(ram_wr_en), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rv_drop"}, 32'(resp_valid), 32'd0);
        n_req++;
    endtask

    initial begin
        int wait_cnt;
        logic [31:0] exp_b2b [3];

        reset      = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_ready_c1", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        mem_init = 1'b0;
        chk("rst_ready_c2", 32'(req_ready), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_data_in", ram_data_in, 32'd0);
        chk("rst_addr_rd", ram_addr_rd, 32'd0);
        chk("rst_addr_wr", ram_addr_wr, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // SW / LW / SB merge / extensions
        do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "sw8");
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, "lw8");
        do_req(1'b1, 3'b000, 32'h9, 32'h000000A5, 1'b0, 32'h0, 1'b1, 32'hDEADA5EF, "sb9");
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hDEADA5EF, 1'b0, 32'h0, "lw8_sb");
        do_req(1'b0, 3'b000, 32'h9, 32'h0, 1'b0, 32'hFFFFFFA5, 1'b0, 32'h0, "lb9");
        do_req(1'b0, 3'b100, 32'h9, 32'h0, 1'b0, 32'h000000A5, 1'b0, 32'h0, "lbu9");
        do_req(1'b0, 3'b001, 32'hA, 32'h0, 1'b0, 32'hFFFFDEAD, 1'b0, 32'h0, "lhA");
        do_req(1'b0, 3'b101, 32'hA, 32'h0, 1'b0, 32'h0000DEAD, 1'b0, 32'h0, "lhuA");
        do_req(1'b0, 3'b001, 32'h8, 32'h0, 1'b0, 32'hFFFFA5EF, 1'b0, 32'h0, "lh8");
        do_req(1'b1, 3'b001, 32'hA, 32'h00001234, 1'b0, 32'h0, 1'b1, 32'h1234A5EF, "shA");
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h1234A5EF, 1'b0, 32'h0, "lw8_sh");

        // Faults
        do_req(1'b0, 3'b001, 32'h5, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "f_lh5");
        do_req(1'b1, 3'b010, 32'h6, 32'h55555555, 1'b1, 32'h0, 1'b0, 32'h0, "f_sw6");
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "f_range");
        do_req(1'b1, 3'b010, 32'h100, 32'h77777777, 1'b1, 32'h0, 1'b0, 32'h0, "f_sw_range");
        do_req(1'b0, 3'b011, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "f_ld011");
        do_req(1'b1, 3'b100, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "f_st100");
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h10000001, 1'b0, 32'h0, "lw4_intact");

        // Reset in the DATA cycle of a store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'hC;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_wr_before", 32'(ram_wr_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_wr_in_reset", 32'(ram_wr_en), 32'd0);
        chk("abort_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_rv_c1", 32'(resp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("abort_rv_c2", 32'(resp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'hC, 32'h0, 1'b0, 32'h10000003, 1'b0, 32'h0, "lwC_after_abort");

        // Back-to-back with req_valid held
        chk("pre_b2b_resp_count", 32'(resp_total), 32'(n_req));
        resp_q.delete();
        exp_b2b[0] = 32'h10000004;
        exp_b2b[1] = 32'h10000005;
        exp_b2b[2] = 32'h10000006;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'h10 + 32'(4 * k);
            wait_cnt = 0;
            while (!req_ready && wait_cnt < 10) begin
                @(posedge clk); #1;
                wait_cnt++;
            end
            chk("b2b_ready", 32'(req_ready), 32'd1);
            chk("b2b_spacing", 32'(wait_cnt), (k == 0) ? 32'd0 : 32'd3);
            @(posedge clk); #1;
            chk("b2b_ready_low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        wait_cnt = 0;
        while (resp_q.size() < 3 && wait_cnt < 12) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("b2b_resp_count", 32'(resp_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < resp_q.size()) chk("b2b_rdata_order", resp_q[k], exp_b2b[k]);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("total_resp_count", 32'(resp_total), 32'(n_req + 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
